// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end. Owns the PC and issues one request at a time on
// a valid/ready instruction-memory port. It feeds the IF/ID pipeline register,
// honouring the hazard unit's stall outputs. An instruction returned during a
// stall is parked in a one-entry skid buffer so it is never fetched twice.
// A taken branch discards the response to a request that is still in flight
// and inserts NOP bubbles into IF/ID.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   Pc_Write       hazard unit: 0 = hold PC
//   If_Id_Write    hazard unit: 0 = hold IF/ID
//   Branch_Taken   redirect request from EX branch resolution
//   Branch_Target  redirect address
//   Imem_Req       fetch request valid (FETCH and DROP states only)
//   Imem_Addr      fetch address, stable until Imem_Ready
//   Imem_Ready     response strobe, Imem_Rdata valid in the same cycle
//   Imem_Rdata     returned instruction
//   If_Id_Pc       PC of the instruction held in IF/ID
//   If_Id_Instr    instruction held in IF/ID
//   If_Id_Valid    1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Pc_Write,
    input  logic            If_Id_Write,
    input  logic            Branch_Taken,
    input  logic [XLEN-1:0] Branch_Target,
    output logic            Imem_Req,
    output logic [XLEN-1:0] Imem_Addr,
    input  logic            Imem_Ready,
    input  logic [XLEN-1:0] Imem_Rdata,
    output logic [XLEN-1:0] If_Id_Pc,
    output logic [XLEN-1:0] If_Id_Instr,
    output logic            If_Id_Valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HELD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t          state_reg,       state_next;
    logic [XLEN-1:0] pc_reg,          pc_next;
    logic [XLEN-1:0] req_addr_reg,    req_addr_next;
    logic [XLEN-1:0] skid_reg,        skid_next;
    logic [XLEN-1:0] if_id_pc_reg,    if_id_pc_next;
    logic [XLEN-1:0] if_id_instr_reg, if_id_instr_next;
    logic            if_id_valid_reg, if_id_valid_next;

    logic            stall;
    logic [XLEN-1:0] req_plus4;

    assign stall     = ~Pc_Write | ~If_Id_Write;
    assign req_plus4 = req_addr_reg + XLEN'(4);   // wraps silently

    assign Imem_Req    = (state_reg == S_FETCH) || (state_reg == S_DROP);
    assign Imem_Addr   = req_addr_reg;
    assign If_Id_Pc    = if_id_pc_reg;
    assign If_Id_Instr = if_id_instr_reg;
    assign If_Id_Valid = if_id_valid_reg;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            pc_reg          <= RESET_PC;
            req_addr_reg    <= RESET_PC;
            skid_reg        <= '0;
            if_id_pc_reg    <= '0;
            if_id_instr_reg <= NOP_INSTR;
            if_id_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            req_addr_reg    <= req_addr_next;
            skid_reg        <= skid_next;
            if_id_pc_reg    <= if_id_pc_next;
            if_id_instr_reg <= if_id_instr_next;
            if_id_valid_reg <= if_id_valid_next;
        end
    end

    // Next-state and datapath logic. A bubble only replaces instruction and
    // valid; the IF/ID PC is left as it was.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        req_addr_next    = req_addr_reg;
        skid_next        = skid_reg;
        if_id_pc_next    = if_id_pc_reg;
        if_id_instr_next = if_id_instr_reg;
        if_id_valid_next = if_id_valid_reg;

        case (state_reg)
            S_IDLE: begin
                // One quiet cycle after reset before the first request.
                state_next = S_FETCH;
                if (Branch_Taken) begin
                    pc_next          = Branch_Target;
                    req_addr_next    = Branch_Target;
                    if_id_instr_next = NOP_INSTR;
                    if_id_valid_next = 1'b0;
                end
            end

            S_FETCH: begin
                if (Imem_Ready) begin
                    if (Branch_Taken) begin
                        pc_next          = Branch_Target;
                        req_addr_next    = Branch_Target;
                        if_id_instr_next = NOP_INSTR;
                        if_id_valid_next = 1'b0;
                    end else if (!stall) begin
                        if_id_pc_next    = req_addr_reg;
                        if_id_instr_next = Imem_Rdata;
                        if_id_valid_next = 1'b1;
                        pc_next          = req_plus4;
                        req_addr_next    = req_plus4;
                    end else begin
                        // Response arrived but the pipe is stalled: park it.
                        skid_next  = Imem_Rdata;
                        state_next = S_HELD;
                    end
                end else begin
                    if (Branch_Taken) begin
                        // Request still outstanding: keep its address stable
                        // and remember the redirect in pc until it completes.
                        pc_next          = Branch_Target;
                        if_id_instr_next = NOP_INSTR;
                        if_id_valid_next = 1'b0;
                        state_next       = S_DROP;
                    end else if (!stall) begin
                        if_id_instr_next = NOP_INSTR;
                        if_id_valid_next = 1'b0;
                    end
                end
            end

            S_HELD: begin
                if (Branch_Taken) begin
                    pc_next          = Branch_Target;
                    req_addr_next    = Branch_Target;
                    if_id_instr_next = NOP_INSTR;
                    if_id_valid_next = 1'b0;
                    state_next       = S_FETCH;
                end else if (!stall) begin
                    if_id_pc_next    = req_addr_reg;
                    if_id_instr_next = skid_reg;
                    if_id_valid_next = 1'b1;
                    pc_next          = req_plus4;
                    req_addr_next    = req_plus4;
                    state_next       = S_FETCH;
                end
            end

            S_DROP: begin
                if (Branch_Taken) begin
                    pc_next = Branch_Target;
                end
                if (Imem_Ready) begin
                    // Stale response is discarded; restart at the newest target.
                    req_addr_next = Branch_Taken ? Branch_Target : pc_reg;
                    pc_next       = Branch_Taken ? Branch_Target : pc_reg;
                    state_next    = S_FETCH;
                end
                if (Branch_Taken || !stall) begin
                    if_id_instr_next = NOP_INSTR;
                    if_id_valid_next = 1'b0;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. The stimulus process pushes the expected fetch
// addresses and the expected IF/ID entries into queues; an independent monitor
// pops and compares whenever a memory handshake or a new valid IF/ID entry is
// observed. A few cycle-exact checks (reset, held state, bubbles, address
// stability) are made directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Pc_Write;
    logic        If_Id_Write;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ready;
    logic [31:0] Imem_Rdata;
    logic [31:0] If_Id_Pc;
    logic [31:0] If_Id_Instr;
    logic        If_Id_Valid;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Pc_Write      (Pc_Write),
        .If_Id_Write   (If_Id_Write),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .Imem_Req      (Imem_Req),
        .Imem_Addr     (Imem_Addr),
        .Imem_Ready    (Imem_Ready),
        .Imem_Rdata    (Imem_Rdata),
        .If_Id_Pc      (If_Id_Pc),
        .If_Id_Instr   (If_Id_Instr),
        .If_Id_Valid   (If_Id_Valid)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_ifid_q[$];
    int          wait_n = 0;
    logic        mem_en = 1'b1;
    int          cnt    = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic wait_addr(input logic [31:0] a);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (rst_n === 1'b1 && Imem_Req === 1'b1 && Imem_Addr === a) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wait_addr: request to %08h not seen within 60 cycles", a);
        end
    endtask

    // Memory model: answers after wait_n wait cycles, decided just after each
    // falling edge so the response is stable around the next rising edge.
    always @(negedge clk) begin
        #1;
        if (rst_n !== 1'b1 || Imem_Req !== 1'b1) begin
            Imem_Ready = 1'b0;
            Imem_Rdata = 32'hDEAD_BEEF;
            cnt        = 0;
        end else if (!mem_en) begin
            Imem_Ready = 1'b0;
            Imem_Rdata = 32'hDEAD_BEEF;
        end else if (cnt >= wait_n) begin
            Imem_Ready = 1'b1;
            Imem_Rdata = mem_data(Imem_Addr);
            cnt        = 0;
        end else begin
            Imem_Ready = 1'b0;
            Imem_Rdata = 32'hDEAD_BEEF;
            cnt++;
        end
    end

    // Monitor: handshakes and new valid IF/ID entries against the queues.
    initial begin
        logic        pv;
        logic [31:0] pp;
        logic [31:0] pi;
        logic [31:0] e;
        pv = 1'b0;
        pp = '0;
        pi = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && Imem_Req === 1'b1 && Imem_Ready === 1'b1) begin
                if (exp_addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fetch_addr: got unexpected fetch %08h expected none", Imem_Addr);
                end else begin
                    e = exp_addr_q.pop_front();
                    check("fetch_addr", Imem_Addr, e);
                    $display("fetch   addr=%08h", Imem_Addr);
                end
            end
            if (If_Id_Valid === 1'b1 && (!pv || If_Id_Pc !== pp || If_Id_Instr !== pi)) begin
                if (exp_ifid_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ifid_entry: got unexpected pc=%08h expected none", If_Id_Pc);
                end else begin
                    e = exp_ifid_q.pop_front();
                    check("ifid_pc", If_Id_Pc, e);
                    check("ifid_instr", If_Id_Instr, mem_data(e));
                    $display("if_id   pc=%08h instr=%08h", If_Id_Pc, If_Id_Instr);
                end
            end
            pv = (If_Id_Valid === 1'b1);
            pp = If_Id_Pc;
            pi = If_Id_Instr;
        end
    end

    // Stimulus
    initial begin
        logic [31:0] addr_seq [11];
        logic [31:0] ifid_seq [9];
        addr_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104,
                     32'h200, 32'h0, 32'h4, 32'h8};
        ifid_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h200,
                     32'h0, 32'h4, 32'h8};
        foreach (addr_seq[i]) exp_addr_q.push_back(addr_seq[i]);
        foreach (ifid_seq[i]) exp_ifid_q.push_back(ifid_seq[i]);

        rst_n         = 1'b0;
        Pc_Write      = 1'b1;
        If_Id_Write   = 1'b1;
        Branch_Taken  = 1'b0;
        Branch_Target = '0;
        Imem_Ready    = 1'b0;
        Imem_Rdata    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        check("rst_req",   {31'b0, Imem_Req},    32'h0);
        check("rst_valid", {31'b0, If_Id_Valid}, 32'h0);
        check("rst_instr", If_Id_Instr,          NOP);
        check("rst_pc",    If_Id_Pc,             32'h0);
        check("rst_addr",  Imem_Addr,            32'h0);
        $display("reset   checked");
        @(negedge clk);
        rst_n = 1'b1;

        // Stall while the response at 0x8 returns
        wait_addr(32'h8);
        Pc_Write    = 1'b0;
        If_Id_Write = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #3;
            check("held_req",   {31'b0, Imem_Req},    32'h0);
            check("held_pc",    If_Id_Pc,             32'h4);
            check("held_valid", {31'b0, If_Id_Valid}, 32'h1);
            $display("stall   cycle=%0d pc=%08h", k, If_Id_Pc);
        end
        @(negedge clk);
        Pc_Write    = 1'b1;
        If_Id_Write = 1'b1;
        wait_n      = 2;

        // Two wait states on the request to 0xC
        @(negedge clk);
        #3;
        check("wait_addr_first", Imem_Addr, 32'hC);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #3;
            check("wait_valid", {31'b0, If_Id_Valid}, 32'h0);
            check("wait_instr", If_Id_Instr,          NOP);
            check("wait_addr",  Imem_Addr,            32'hC);
            $display("wait    cycle=%0d addr=%08h", k, Imem_Addr);
        end

        // Redirect while the request to 0x10 is outstanding
        wait_addr(32'h10);
        Branch_Taken  = 1'b1;
        Branch_Target = 32'h100;
        @(negedge clk);
        Branch_Taken = 1'b0;
        #3;
        check("drop_req",   {31'b0, Imem_Req},    32'h1);
        check("drop_addr",  Imem_Addr,            32'h10);
        check("drop_valid", {31'b0, If_Id_Valid}, 32'h0);
        @(negedge clk);
        #3;
        check("drop_addr2", Imem_Addr, 32'h10);
        $display("drop    addr=%08h", Imem_Addr);

        // Redirect with stall asserted while HELD
        wait_addr(32'h104);
        wait_n   = 0;
        Pc_Write = 1'b0;
        @(negedge clk);
        Branch_Taken  = 1'b1;
        Branch_Target = 32'h200;
        #3;
        check("held2_req", {31'b0, Imem_Req}, 32'h0);
        check("held2_pc",  If_Id_Pc,          32'h100);
        @(negedge clk);
        Branch_Taken = 1'b0;
        Pc_Write     = 1'b1;
        wait_n       = 2;
        #3;
        check("hbr_valid", {31'b0, If_Id_Valid}, 32'h0);
        check("hbr_instr", If_Id_Instr,          NOP);
        check("hbr_pc",    If_Id_Pc,             32'h100);
        check("hbr_addr",  Imem_Addr,            32'h200);
        $display("heldbr  addr=%08h", Imem_Addr);

        // Reset while in DROP
        wait_addr(32'h204);
        Branch_Taken  = 1'b1;
        Branch_Target = 32'h300;
        @(negedge clk);
        Branch_Taken = 1'b0;
        rst_n        = 1'b0;
        wait_n       = 0;
        #3;
        check("pre_rst_req",  {31'b0, Imem_Req}, 32'h1);
        check("pre_rst_addr", Imem_Addr,         32'h204);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        check("mid_rst_req",   {31'b0, Imem_Req},    32'h0);
        check("mid_rst_valid", {31'b0, If_Id_Valid}, 32'h0);
        check("mid_rst_instr", If_Id_Instr,          NOP);
        check("mid_rst_addr",  Imem_Addr,            32'h0);
        @(negedge clk);
        #3;
        check("restart_req",  {31'b0, Imem_Req}, 32'h1);
        check("restart_addr", Imem_Addr,         32'h0);
        $display("restart addr=%08h", Imem_Addr);

        // Drain the scoreboard, then freeze memory
        for (int i = 0; i < 100 && exp_addr_q.size() != 0; i++) @(negedge clk);
        mem_en = 1'b0;
        check("addr_drain", exp_addr_q.size(), 32'd0);
        for (int i = 0; i < 100 && exp_ifid_q.size() != 0; i++) @(negedge clk);
        check("ifid_drain", exp_ifid_q.size(), 32'd0);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
